// File: rtl/seven_seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package    : seven_seg_pkg
// Description: Shared definitions for the two-digit seven-segment scan
//              controller: blank segment code, scan state encoding and the
//              default 12 MHz timing constants.
// Revision   : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  // Active-low segment bus value with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // 1 ms per digit and 10 us of blanking at 12 MHz.
  localparam int DEFAULT_DIGIT_CYCLES = 12000;
  localparam int DEFAULT_BLANK_CYCLES = 120;

  // Bit 0 set = a digit is lit, bit 1 set = high-nibble half of the frame.
  typedef enum logic [1:0] {
    BLANK_LO = 2'd0,
    SHOW_LO  = 2'd1,
    BLANK_HI = 2'd2,
    SHOW_HI  = 2'd3
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface  : seven_seg_scan_ctrl_if
// Description: Byte load handshake into the scan controller.
//   load_valid  producer -> controller  load_data is presented
//   load_data   producer -> controller  byte to display ([3:0] digit 0)
//   load_ready  controller -> producer  pending slot is free
//   Modports: master (producer side), slave (controller side).
// Revision   : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_ctrl_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module     : nibble_to_seven_seg
// Description: Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
//              Digits 0-9 get their usual glyphs; 10-15 share a fallback
//              glyph (segments a, d and g lit).
//   nibble  in   4  value to render
//   seg_n   out  7  active-low segment pattern
// Revision   : 1.0 - initial release
// ============================================================================
module nibble_to_seven_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  logic [6:0] seg_on;  // active-high pattern

  always_comb begin
    seg_on = 7'h49;
    case (nibble)
      4'h0: seg_on = 7'h3F;
      4'h1: seg_on = 7'h06;
      4'h2: seg_on = 7'h5B;
      4'h3: seg_on = 7'h4F;
      4'h4: seg_on = 7'h66;
      4'h5: seg_on = 7'h6D;
      4'h6: seg_on = 7'h7D;
      4'h7: seg_on = 7'h07;
      4'h8: seg_on = 7'h7F;
      4'h9: seg_on = 7'h6F;
      default: seg_on = 7'h49;
    endcase
  end

  assign seg_n = ~seg_on;

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : seven_seg_scan_ctrl
// Description: Time-multiplexed scan controller for a two-digit, active-low,
//              common-segment seven-segment display. A byte accepted over the
//              load handshake is shown low nibble on digit 0, high nibble on
//              digit 1, with a blanking gap before each digit.
//   clk            in   1  system clock
//   rst            in   1  synchronous active-high reset
//   load           slave modport: load_valid / load_data[7:0] / load_ready
//   blank_leading  in   1  darken digit 1 when the displayed high nibble is 0
//   seg_n          out  7  active-low segments {g,f,e,d,c,b,a}
//   digit_sel      out  1  0 = digit 0, 1 = digit 1
//   frame_done     out  1  pulse on the last cycle of each frame
// Revision   : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = DEFAULT_DIGIT_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scan_ctrl_if.slave load,
  input  logic                 blank_leading,
  output logic [6:0]           seg_n,
  output logic                 digit_sel,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(max_int(DIGIT_CYCLES, BLANK_CYCLES));
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             phase_last;
  logic             frame_end;

  logic [7:0]       disp;
  logic [7:0]       pending;
  logic             pending_full;

  logic [3:0]       dec_nibble;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_next;

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK_LO;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    phase_last = 1'b0;
    case (state)
      BLANK_LO, BLANK_HI: phase_last = (cnt == BLANK_LAST);
      default:            phase_last = (cnt == DIGIT_LAST);
    endcase
    if (phase_last) begin
      cnt_next = '0;
      case (state)
        BLANK_LO: state_next = SHOW_LO;
        SHOW_LO:  state_next = BLANK_HI;
        BLANK_HI: state_next = SHOW_HI;
        default:  state_next = BLANK_LO;
      endcase
    end
  end

  assign frame_end  = (state == SHOW_HI) && phase_last;
  assign frame_done = frame_end;

  // ---------------- segment path ----------------
  // Outputs are registered from the next state so they line up with the
  // state they belong to. Bit 1 of the state picks the nibble half.
  assign dec_nibble = state_next[1] ? disp[7:4] : disp[3:0];

  nibble_to_seven_seg u_decoder (
    .nibble (dec_nibble),
    .seg_n  (dec_seg)
  );

  always_comb begin
    seg_next = SEG_OFF;
    if (state_next == SHOW_LO) begin
      seg_next = dec_seg;
    end else if (state_next == SHOW_HI) begin
      if (!(blank_leading && (disp[7:4] == 4'h0))) begin
        seg_next = dec_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n     <= SEG_OFF;
      digit_sel <= 1'b0;
    end else begin
      seg_n     <= seg_next;
      digit_sel <= state_next[1];
    end
  end

  // ---------------- load handshake ----------------
  // The frame boundary drain and a new capture are exclusive: capture needs
  // the slot empty, drain needs it full.
  assign load.load_ready = !pending_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp         <= 8'h00;
      pending      <= 8'h00;
      pending_full <= 1'b0;
    end else if (frame_end && pending_full) begin
      disp         <= pending;
      pending_full <= 1'b0;
    end else if (load.load_valid && !pending_full) begin
      pending      <= load.load_data;
      pending_full <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_seven_seg_scan_ctrl
// Description: Self-checking bench for seven_seg_scan_ctrl with
//              DIGIT_CYCLES=4, BLANK_CYCLES=2. Accepted bytes go to a
//              scoreboard queue and are popped when a frame boundary moves
//              them onto the display; every cycle the outputs are compared.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;
  import seven_seg_pkg::*;

  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int HALF  = BC + DC;
  localparam int FRAME = 2 * HALF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank_leading = 1'b0;
  logic [6:0] seg_n;
  logic       digit_sel;
  logic       frame_done;

  seven_seg_scan_ctrl_if lif ();

  seven_seg_scan_ctrl #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (lif),
    .blank_leading (blank_leading),
    .seg_n         (seg_n),
    .digit_sel     (digit_sel),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         phase = 0;
  logic [7:0] cur_disp = 8'h00;
  logic       m_pend_full = 1'b0;
  logic       prev_sel = 1'b0;
  logic [7:0] sb_q[$];
  logic [7:0] tx_q[$];

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;  4'h4: on = 7'h66;  4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;  4'h7: on = 7'h07;  4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      default: on = 7'h49;
    endcase
    return ~on;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One display cycle: drive producer, compare outputs, advance the model.
  task automatic step_cycle();
    logic [6:0] seg_exp;
    logic       sel_exp;
    logic       xfer;
    int         p;
    lif.load_valid = (tx_q.size() != 0);
    lif.load_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    sel_exp = (phase >= HALF);
    p       = phase % HALF;
    seg_exp = SEG_OFF;
    if (p >= BC) begin
      if (!sel_exp) seg_exp = glyph(cur_disp[3:0]);
      else if (!(blank_leading && cur_disp[7:4] == 4'h0)) seg_exp = glyph(cur_disp[7:4]);
    end
    chk($sformatf("seg_n@ph%0d", phase), {1'b0, seg_n}, {1'b0, seg_exp});
    chk($sformatf("digit_sel@ph%0d", phase), {7'd0, digit_sel}, {7'd0, sel_exp});
    chk($sformatf("frame_done@ph%0d", phase), {7'd0, frame_done}, {7'd0, (phase == FRAME - 1)});
    chk($sformatf("load_ready@ph%0d", phase), {7'd0, lif.load_ready}, {7'd0, !m_pend_full});
    chk($sformatf("sel_change_lit@ph%0d", phase),
        {7'd0, (digit_sel === prev_sel) || (seg_n === SEG_OFF)}, 8'd1);
    xfer = lif.load_valid && !m_pend_full;
    if (phase == FRAME - 1 && m_pend_full) begin
      cur_disp    = sb_q.pop_front();
      m_pend_full = 1'b0;
    end else if (xfer) begin
      sb_q.push_back(lif.load_data);
      m_pend_full = 1'b1;
      void'(tx_q.pop_front());
    end
    prev_sel = digit_sel;
    phase    = (phase + 1) % FRAME;
    @(negedge clk);
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) step_cycle();
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = 8'h00;
    repeat (3) @(negedge clk);
    // Outputs while reset is held.
    chk("rst_seg_n", {1'b0, seg_n}, 8'h7F);
    chk("rst_digit_sel", {7'd0, digit_sel}, 8'd0);
    chk("rst_frame_done", {7'd0, frame_done}, 8'd0);
    chk("rst_load_ready", {7'd0, lif.load_ready}, 8'd1);
    rst = 1'b0;

    // Idle frame showing 00.
    run_frames(1);

    // Load 37 mid-frame: current frame stays 00, next frame shows 37.
    repeat (5) step_cycle();
    tx_q.push_back(8'h37);
    repeat (FRAME - 5) step_cycle();
    chk("disp37_lo_glyph", {1'b0, glyph(cur_disp[3:0])}, 8'h78);
    run_frames(1);

    // Back-to-back 12 then 34 with valid held.
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    run_frames(3);

    // Leading-zero blanking with 05.
    blank_leading = 1'b1;
    tx_q.push_back(8'h05);
    run_frames(2);
    chk("disp05_lo_glyph", {1'b0, glyph(cur_disp[3:0])}, 8'h12);
    blank_leading = 1'b0;
    run_frames(1);

    // Fallback glyph on the high digit.
    tx_q.push_back(8'hA9);
    run_frames(2);
    chk("dispA9_hi_glyph", {1'b0, glyph(cur_disp[7:4])}, 8'h36);

    // Reset during SHOW_LO with a byte pending.
    tx_q.push_back(8'hEE);
    repeat (4) step_cycle();
    rst = 1'b1;
    tx_q.delete();
    lif.load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    phase       = 0;
    cur_disp    = 8'h00;
    m_pend_full = 1'b0;
    prev_sel    = 1'b0;
    sb_q.delete();
    run_frames(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
